// File: rtl/alarm_tone_gen.sv
// Alarm buzzer driver: self-generated square tone with selectable beat patterns, repeat limit and mute.
// States: IDLE waits for a request, SOUND plays the pattern, MUTED stays silent until the request drops.
module alarm_tone_gen #(
    parameter int                   DIV_W        = 16,
    parameter int                   TONE_DIV_HI  = 25000,
    parameter int                   TONE_DIV_LO  = 37500,
    parameter int                   BEAT_W       = 24,
    parameter int                   BEAT_LEN     = 5000000,
    parameter int                   NUM_BEATS    = 8,
    parameter logic [NUM_BEATS-1:0] PATTERN      = 8'b0101_0101,
    parameter int                   REPEAT_LIMIT = 0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         alarm_req,
    input  logic [1:0]                   mode,
    input  logic                         ack,
    output logic                         Music,
    output logic                         active,
    output logic [$clog2(NUM_BEATS)-1:0] beat_idx
);

    localparam int IDX_W = $clog2(NUM_BEATS);
    localparam int REP_W = (REPEAT_LIMIT < 2) ? 1 : $clog2(REPEAT_LIMIT + 1);

    localparam logic [DIV_W-1:0]  HALF_HI   = DIV_W'(TONE_DIV_HI);
    localparam logic [DIV_W-1:0]  HALF_LO   = DIV_W'(TONE_DIV_LO);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BEATS - 1);
    localparam logic [REP_W:0]    REP_LIM   = (REP_W + 1)'(REPEAT_LIMIT);
    localparam logic [REP_W-1:0]  REP_MAX   = '1;

    generate
        if (BEAT_LEN < 2 || longint'(BEAT_LEN - 1) >= (longint'(1) << BEAT_W)) begin : g_bad_beat
            $error("alarm_tone_gen: BEAT_W cannot hold BEAT_LEN-1 or BEAT_LEN < 2");
        end
        if (TONE_DIV_HI < 2 || TONE_DIV_LO < 2 ||
            longint'(TONE_DIV_HI - 1) >= (longint'(1) << DIV_W) ||
            longint'(TONE_DIV_LO - 1) >= (longint'(1) << DIV_W)) begin : g_bad_div
            $error("alarm_tone_gen: DIV_W cannot hold tone divider or divider < 2");
        end
        if (NUM_BEATS < 2 || (NUM_BEATS & (NUM_BEATS - 1)) != 0) begin : g_bad_beats
            $error("alarm_tone_gen: NUM_BEATS must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOUND = 2'd1,
        ST_MUTED = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cur_mode;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [IDX_W-1:0]  r_beat_idx;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_tone;
    logic              r_music;

    logic [DIV_W-1:0]  w_half_div;
    logic              w_div_last;
    logic              w_beat_last;
    logic              w_pat_wrap;
    logic              w_rep_hit;
    logic              w_tone_gate;

    always_comb begin
        w_half_div  = (r_cur_mode == 2'd3 && r_beat_idx[0]) ? HALF_LO : HALF_HI;
        w_div_last  = (r_div_cnt == w_half_div - 1'b1);
        w_beat_last = (r_beat_cnt == BEAT_LAST);
        w_pat_wrap  = w_beat_last && (r_beat_idx == IDX_LAST);
        w_rep_hit   = (REPEAT_LIMIT != 0) && (({1'b0, r_rep_cnt} + 1'b1) == REP_LIM);
        w_tone_gate = (r_cur_mode == 2'd2) ? PATTERN[r_beat_idx] : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_cur_mode <= 2'd0;
            r_div_cnt  <= '0;
            r_beat_cnt <= '0;
            r_beat_idx <= '0;
            r_rep_cnt  <= '0;
            r_tone     <= 1'b0;
            r_music    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_music <= 1'b0;
                    if (alarm_req && mode != 2'd0) begin
                        r_state    <= ST_SOUND;
                        r_cur_mode <= mode;
                        r_div_cnt  <= '0;
                        r_beat_cnt <= '0;
                        r_beat_idx <= '0;
                        r_rep_cnt  <= '0;
                        r_tone     <= 1'b0;
                    end
                end
                ST_SOUND: begin
                    r_music <= r_tone & w_tone_gate;
                    if (!alarm_req) begin
                        r_state    <= ST_IDLE;
                        r_beat_idx <= '0;
                    end else if (ack || (w_pat_wrap && w_rep_hit)) begin
                        r_state    <= ST_MUTED;
                        r_beat_idx <= '0;
                    end else if (w_pat_wrap && mode == 2'd0) begin
                        r_state    <= ST_IDLE;
                        r_beat_idx <= '0;
                    end else if (w_beat_last) begin
                        // every beat restarts the tone in a known phase
                        r_beat_cnt <= '0;
                        r_div_cnt  <= '0;
                        r_tone     <= 1'b0;
                        r_beat_idx <= r_beat_idx + 1'b1;
                        if (w_pat_wrap) begin
                            r_cur_mode <= mode;
                            if (r_rep_cnt != REP_MAX) begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (w_div_last) begin
                            r_div_cnt <= '0;
                            r_tone    <= ~r_tone;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                end
                ST_MUTED: begin
                    r_music <= 1'b0;
                    if (!alarm_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_music <= 1'b0;
                end
            endcase
        end
    end

    assign Music    = r_music;
    assign active   = (r_state == ST_SOUND);
    assign beat_idx = r_beat_idx;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Bench for alarm_tone_gen: directed scenarios plus random traffic against a cycle-count reference model.
module tb_alarm_tone_gen;

    localparam int         HI  = 2;
    localparam int         LO  = 4;
    localparam int         BL  = 8;
    localparam int         NB  = 4;
    localparam int         LIM = 2;
    localparam logic [3:0] PAT = 4'b0101;

    localparam int M_IDLE  = 0;
    localparam int M_SOUND = 1;
    localparam int M_MUTED = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       alarm_req;
    logic [1:0] mode;
    logic       ack;
    logic       Music;
    logic       active;
    logic [1:0] beat_idx;

    int errors = 0;
    int checks = 0;

    int         m_st;
    int         m_c;
    logic [1:0] m_pmode;
    logic       exp_music;
    logic       exp_active;
    logic [1:0] exp_idx;

    wire [3:0] w_obs = {Music, active, beat_idx};
    wire [3:0] w_exp = {exp_music, exp_active, exp_idx};

    alarm_tone_gen #(
        .DIV_W(16),
        .TONE_DIV_HI(HI),
        .TONE_DIV_LO(LO),
        .BEAT_W(24),
        .BEAT_LEN(BL),
        .NUM_BEATS(NB),
        .PATTERN(PAT),
        .REPEAT_LIMIT(LIM)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .alarm_req(alarm_req),
        .mode(mode),
        .ack(ack),
        .Music(Music),
        .active(active),
        .beat_idx(beat_idx)
    );

    always #5 CLK = ~CLK;

    // Reference: m_c counts cycles since entering SOUND; tone phase is derived arithmetically from it.
    task automatic model_step(input logic req, input logic ak, input logic [1:0] md);
        int         beat;
        int         off;
        int         half;
        logic       tone_v;
        logic       gate_v;
        logic [3:0] pat_v;
        pat_v     = PAT;
        exp_music = 1'b0;
        case (m_st)
            M_SOUND: begin
                beat      = (m_c / BL) % NB;
                off       = m_c % BL;
                half      = (m_pmode == 2'd3 && (beat % 2) == 1) ? LO : HI;
                tone_v    = ((off / half) % 2) == 1;
                gate_v    = (m_pmode == 2'd2) ? pat_v[beat] : 1'b1;
                exp_music = tone_v & gate_v;
                if (!req) begin
                    m_st = M_IDLE;
                end else if (ak) begin
                    m_st = M_MUTED;
                end else if (off == BL - 1 && beat == NB - 1 && (m_c / (BL * NB)) + 1 == LIM) begin
                    m_st = M_MUTED;
                end else if (off == BL - 1 && beat == NB - 1 && md == 2'd0) begin
                    m_st = M_IDLE;
                end else begin
                    if (off == BL - 1 && beat == NB - 1) m_pmode = md;
                    m_c++;
                end
            end
            M_MUTED: begin
                if (!req) m_st = M_IDLE;
            end
            default: begin
                if (req && md != 2'd0) begin
                    m_st    = M_SOUND;
                    m_c     = 0;
                    m_pmode = md;
                end
            end
        endcase
        exp_active = (m_st == M_SOUND);
        exp_idx    = (m_st == M_SOUND) ? 2'((m_c / BL) % NB) : 2'd0;
    endtask

    task automatic model_reset();
        m_st       = M_IDLE;
        m_c        = 0;
        m_pmode    = 2'd0;
        exp_music  = 1'b0;
        exp_active = 1'b0;
        exp_idx    = 2'd0;
    endtask

    task automatic tick(input logic req, input logic ak, input logic [1:0] md);
        alarm_req = req;
        ack       = ak;
        mode      = md;
        model_step(req, ak, md);
        @(posedge CLK);
        #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; alarm_req = 1'b0; ack = 1'b0; mode = 2'd0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (Music !== 1'b0) begin errors++; $display("FAIL reset_music got=%b exp=0", Music); end
        checks++;
        if ({active, beat_idx} !== 3'b000) begin errors++; $display("FAIL reset_state got=%b exp=000", {active, beat_idx}); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 2'd0);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL mode0_idle k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
        tick(1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_continuous();
        int first_hi;
        first_hi = -1;
        for (int k = 0; k <= 40; k++) begin
            tick(1'b1, 1'b0, 2'd1);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL continuous k=%0d got=%b exp=%b", k, w_obs, w_exp); end
            if (first_hi < 0 && Music === 1'b1) first_hi = k;
        end
        checks++;
        if (first_hi != 3) begin errors++; $display("FAIL first_music got=%0d exp=3", first_hi); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 2'd1);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL continuous_drop k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
    endtask

    task automatic test_gated();
        logic [1:0] idx_seen [5];
        logic       gated_hi;
        gated_hi = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            tick(1'b1, 1'b0, 2'd2);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL gated k=%0d got=%b exp=%b", k, w_obs, w_exp); end
            if (k % 8 == 0 && k <= 32) idx_seen[k / 8] = beat_idx;
            if (((k >= 9 && k <= 16) || (k >= 25 && k <= 32)) && Music !== 1'b0) gated_hi = 1'b1;
        end
        checks++;
        if ({idx_seen[0], idx_seen[1], idx_seen[2], idx_seen[3], idx_seen[4]} !== 10'b00_01_10_11_00) begin
            errors++;
            $display("FAIL beat_seq got=%0d,%0d,%0d,%0d,%0d exp=0,1,2,3,0",
                     idx_seen[0], idx_seen[1], idx_seen[2], idx_seen[3], idx_seen[4]);
        end
        checks++;
        if (gated_hi !== 1'b0) begin errors++; $display("FAIL gated_off_beats got=1 exp=0"); end
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 2'd2);
    endtask

    task automatic test_siren();
        logic m12;
        logic m13;
        m12 = 1'bx; m13 = 1'bx;
        for (int k = 0; k <= 40; k++) begin
            tick(1'b1, 1'b0, 2'd3);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL siren k=%0d got=%b exp=%b", k, w_obs, w_exp); end
            if (k == 12) m12 = Music;
            if (k == 13) m13 = Music;
        end
        checks++;
        if ({m12, m13} !== 2'b01) begin errors++; $display("FAIL siren_low_phase got=%b exp=01", {m12, m13}); end
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 2'd3);
    endtask

    task automatic test_repeat_limit();
        logic [1:0] md;
        logic       a63, a64, m66;
        md = 2'($urandom_range(1, 3));
        a63 = 1'bx; a64 = 1'bx; m66 = 1'bx;
        for (int k = 0; k <= 68; k++) begin
            tick(1'b1, 1'b0, md);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL repeat md=%0d k=%0d got=%b exp=%b", md, k, w_obs, w_exp); end
            if (k == 63) a63 = active;
            if (k == 64) a64 = active;
            if (k == 66) m66 = Music;
        end
        checks++;
        if ({a63, a64, m66} !== 3'b100) begin errors++; $display("FAIL repeat_mute got=%b exp=100", {a63, a64, m66}); end
        tick(1'b0, 1'b0, md);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, md);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL rearm k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, md);
    endtask

    task automatic test_ack();
        logic a11, m12, act_after;
        a11 = 1'bx; m12 = 1'bx;
        for (int k = 0; k <= 20; k++) begin
            tick(1'b1, (k == 11) || (k == 15), 2'd1);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL ack k=%0d got=%b exp=%b", k, w_obs, w_exp); end
            if (k == 11) a11 = active;
            if (k == 12) m12 = Music;
        end
        checks++;
        if ({a11, m12} !== 2'b00) begin errors++; $display("FAIL ack_mute got=%b exp=00", {a11, m12}); end
        tick(1'b0, 1'b0, 2'd1);
        for (int k = 0; k <= 5; k++) tick(1'b1, 1'b0, 2'd2);
        tick(1'b0, 1'b1, 2'd2);
        checks++;
        if (w_obs !== w_exp) begin errors++; $display("FAIL ack_with_drop got=%b exp=%b", w_obs, w_exp); end
        tick(1'b1, 1'b0, 2'd2);
        act_after = active;
        checks++;
        if (act_after !== 1'b1 || w_obs !== w_exp) begin errors++; $display("FAIL rearm_after_drop got=%b exp=%b", w_obs, w_exp); end
        tick(1'b0, 1'b0, 2'd2);
        tick(1'b0, 1'b1, 2'd1);
        tick(1'b1, 1'b0, 2'd1);
        checks++;
        if (w_obs !== w_exp) begin errors++; $display("FAIL ack_in_idle got=%b exp=%b", w_obs, w_exp); end
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 2'd1);
    endtask

    task automatic test_mode_switch();
        logic m27, m43;
        m27 = 1'bx; m43 = 1'bx;
        for (int k = 0; k <= 44; k++) begin
            tick(1'b1, 1'b0, (k < 13) ? 2'd1 : 2'd2);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL mode_switch k=%0d got=%b exp=%b", k, w_obs, w_exp); end
            if (k == 27) m27 = Music;
            if (k == 43) m43 = Music;
        end
        checks++;
        if ({m27, m43} !== 2'b10) begin errors++; $display("FAIL switch_at_wrap got=%b exp=10", {m27, m43}); end
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 2'd2);
    endtask

    task automatic test_random();
        logic       rreq;
        logic [1:0] rmode;
        rreq  = 1'b1;
        rmode = 2'($urandom_range(1, 3));
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 99) < 2) rreq = ~rreq;
            if ($urandom_range(0, 99) < 3) rmode = 2'($urandom_range(0, 3));
            tick(rreq, $urandom_range(0, 99) < 2, rmode);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL random k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) tick(1'b0, 1'b0, 2'd0);
        for (int k = 0; k <= 11; k++) begin
            tick(1'b1, 1'b0, 2'd1);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL pre_reset k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
        #3;
        RST_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if (Music !== 1'b0) begin errors++; $display("FAIL async_music got=%b exp=0", Music); end
        checks++;
        if (active !== 1'b0) begin errors++; $display("FAIL async_active got=%b exp=0", active); end
        checks++;
        if (beat_idx !== 2'd0) begin errors++; $display("FAIL async_beat_idx got=%0d exp=0", beat_idx); end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick(1'b1, 1'b0, 2'd2);
            checks++;
            if (w_obs !== w_exp) begin errors++; $display("FAIL post_reset k=%0d got=%b exp=%b", k, w_obs, w_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gated();
        test_siren();
        test_repeat_limit();
        test_ack();
        test_mode_switch();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
